pcie_tx_arbiter: RTL
====================

Name: pcie_tx_arbiter

Overview:
- Shares the single 32-bit AXI-Stream TX port of the PCIe bridge between two TLP sources: requester 0 (completion engine) and requester 1 (DMA write/MSI engine).
- Grants whole packets, alternating round-robin between requesters.
- Does not start a packet unless the core reports enough TX buffers.
- Answers the core's configuration-TLP request (tx_cfg_req/tx_cfg_gnt) only at packet boundaries.
- Counts TLPs dropped by the core.
- Sits between the TLP engines and pcie_axi_bridge, in the user clock domain.

Parameters:
- MIN_BUF_AV, 6'd2: minimum tx_buf_av required to start a new packet.
- CFG_HOLD, 1: 1 = tx_cfg_gnt stays high as long as tx_cfg_req is high; 0 = one-cycle gnt pulse per req rising edge.

Ports:
- clk  in  1  user clock (bridge user_clk_out)
- rst  in  1  asynchronous, active-high reset (bridge user_reset_out)
- r0_tdata  in  32  requester 0 data
- r0_tkeep  in  4  requester 0 keep
- r0_tuser  in  4  requester 0 tuser
- r0_tlast  in  1  requester 0 last beat of packet
- r0_tvalid  in  1  requester 0 valid
- r0_tready  out  1  requester 0 ready
- r1_tdata, r1_tkeep, r1_tuser, r1_tlast, r1_tvalid, r1_tready: same directions and widths as requester 0, for requester 1
- s_axis_tx_tdata  out  32  to bridge
- s_axis_tx_tkeep  out  4  to bridge
- s_axis_tx_tuser  out  4  to bridge
- s_axis_tx_tlast  out  1  to bridge
- s_axis_tx_tvalid  out  1  to bridge
- s_axis_tx_tready  in  1  from bridge
- tx_buf_av  in  6  free TX buffers reported by the core
- tx_cfg_req  in  1  core wants to send a config TLP
- tx_cfg_gnt  out  1  grant to core
- tx_err_drop  in  1  core dropped a TLP (one-cycle pulse)
- drop_count  out  16  saturating count of tx_err_drop pulses
- busy  out  1  a packet grant is active
- grant_id  out  1  requester currently or last granted

Behaviour:
- Reset values:
  - State IDLE.
  - All s_axis_tx_* outputs 0.
  - r0_tready = r1_tready = 0.
  - tx_cfg_gnt = 0, drop_count = 0, busy = 0, grant_id = 0.
  - Round-robin pointer = 0, so requester 0 wins the first tie.
- States: IDLE, GNT0, GNT1, CFG.
- IDLE:
  - If tx_cfg_req=1: go to CFG next edge. Config requests have priority over new packets.
  - Else if tx_buf_av >= MIN_BUF_AV (unsigned 6-bit compare) and any rX_tvalid=1: grant a requester next edge.
    - Only one valid: grant that one.
    - Both valid: grant the one indicated by the pointer.
  - grant_id updates on the grant edge.
- GNTx datapath:
  - s_axis_tx_{tdata,tkeep,tuser,tlast,tvalid} = rX_* combinationally. Zero latency, no registering.
  - rX_tready = s_axis_tx_tready; the other requester's tready = 0.
  - Outside GNT states: s_axis_tx_tvalid = 0, data outputs 0.
- GNTx exit:
  - On a beat with rX_tvalid & s_axis_tx_tready & rX_tlast: go to IDLE and set pointer = ~X.
  - Exactly one IDLE bubble cycle between packets.
- Lock-in during a grant:
  - tx_cfg_req, tx_buf_av changes and the other requester's tvalid are ignored until tlast is accepted.
  - A requester dropping tvalid mid-packet holds the grant; there is no timeout.
- CFG:
  - CFG_HOLD=1: tx_cfg_gnt=1 while in CFG. Return to IDLE on the edge after tx_cfg_req falls.
  - CFG_HOLD=0: tx_cfg_gnt=1 for exactly one cycle, then IDLE. A new pulse requires tx_cfg_req to have been seen low in between.
  - No requester is granted while in CFG.
- drop_count:
  - Increments on each clk with tx_err_drop=1, in any state.
  - Saturates at 16'hFFFF, no wrap.
- busy = (state==GNT0 | state==GNT1).
- Simultaneous events:
  - In IDLE with tx_cfg_req and tvalid both present, CFG wins.
  - Start and end of a packet never occur in the same cycle.
- Reset mid-packet:
  - Asynchronously forces IDLE and zeros all outputs immediately.
  - The partial packet is abandoned; requesters must restart from their first beat.
- tx_buf_av is sampled only in IDLE at the grant decision.

Test Plan:
- Single requester: r0 sends a 4-beat packet with tx_buf_av=8 and tready=1 -> grant on the cycle after r0_tvalid; 4 beats appear unmodified on s_axis_tx; IDLE one cycle after tlast; grant_id=0.
- Fairness: r0 and r1 both continuously valid with 3-beat packets -> grant order 0,1,0,1; exactly one bubble cycle between packets; no beat interleaving.
- Buffer gating: tx_buf_av=1 with r1_tvalid=1 -> no grant; raise tx_buf_av to 2 -> grant on the next edge; lower it to 0 mid-packet -> packet still completes.
- Config handshake (CFG_HOLD=1): tx_cfg_req rises during beat 2 of a 5-beat packet -> tx_cfg_gnt=0 until tlast is accepted; gnt rises the cycle after the IDLE cycle; gnt falls one cycle after req falls; r1 is granted afterward.
- Backpressure and drops: tready toggled 1,0,0,1 during a packet -> rX_tready mirrors it and data is held stable; 3 tx_err_drop pulses -> drop_count=3; preload near saturation and pulse -> drop_count stays 16'hFFFF.
- Async reset mid-packet: assert rst during beat 2 -> s_axis_tx_tvalid=0 and busy=0 without waiting for a clock edge; after release, the first request is granted to r0.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// Packet-level round-robin arbiter of two TLP sources onto the PCIe AXI-Stream TX port.
// Latency: grant one cycle after a request seen in IDLE; datapath is combinational (zero latency).
// Backpressure: s_axis_tx_tready passes straight to the granted requester; the other sees tready=0.
module pcie_tx_arbiter #(
  parameter logic [5:0] MIN_BUF_AV = 6'd2,
  parameter bit         CFG_HOLD   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] r0_tdata,
  input  logic [3:0]  r0_tkeep,
  input  logic [3:0]  r0_tuser,
  input  logic        r0_tlast,
  input  logic        r0_tvalid,
  output logic        r0_tready,
  input  logic [31:0] r1_tdata,
  input  logic [3:0]  r1_tkeep,
  input  logic [3:0]  r1_tuser,
  input  logic        r1_tlast,
  input  logic        r1_tvalid,
  output logic        r1_tready,
  output logic [31:0] s_axis_tx_tdata,
  output logic [3:0]  s_axis_tx_tkeep,
  output logic [3:0]  s_axis_tx_tuser,
  output logic        s_axis_tx_tlast,
  output logic        s_axis_tx_tvalid,
  input  logic        s_axis_tx_tready,
  input  logic [5:0]  tx_buf_av,
  input  logic        tx_cfg_req,
  output logic        tx_cfg_gnt,
  input  logic        tx_err_drop,
  output logic [15:0] drop_count,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, CFG} state_t;

  state_t      state_q;
  logic        rr_q;          // requester that wins the next tie
  logic        gnt_q;
  logic        busy_q;
  logic        grant_id_q;
  logic        cfg_armed_q;   // req seen low since the last one-shot grant
  logic [15:0] drop_count_q;
  logic [15:0] drop_count_d;
  logic        pick_d;
  logic        buf_ok_d;

  // Grant decision inputs: tie goes to the pointer, otherwise the lone valid requester
  always_comb begin
    buf_ok_d = (tx_buf_av >= MIN_BUF_AV);
    pick_d   = (r0_tvalid && r1_tvalid) ? rr_q : r1_tvalid;
  end

  // Steer the granted requester onto the TX port; everything else is held at zero
  always_comb begin
    s_axis_tx_tdata  = 32'd0;
    s_axis_tx_tkeep  = 4'd0;
    s_axis_tx_tuser  = 4'd0;
    s_axis_tx_tlast  = 1'b0;
    s_axis_tx_tvalid = 1'b0;
    r0_tready        = 1'b0;
    r1_tready        = 1'b0;
    case (state_q)
      GNT0: begin
        s_axis_tx_tdata  = r0_tdata;
        s_axis_tx_tkeep  = r0_tkeep;
        s_axis_tx_tuser  = r0_tuser;
        s_axis_tx_tlast  = r0_tlast;
        s_axis_tx_tvalid = r0_tvalid;
        r0_tready        = s_axis_tx_tready;
      end
      GNT1: begin
        s_axis_tx_tdata  = r1_tdata;
        s_axis_tx_tkeep  = r1_tkeep;
        s_axis_tx_tuser  = r1_tuser;
        s_axis_tx_tlast  = r1_tlast;
        s_axis_tx_tvalid = r1_tvalid;
        r1_tready        = s_axis_tx_tready;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with registered status outputs; grants are held until tlast is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      busy_q      <= 1'b0;
      grant_id_q  <= 1'b0;
      cfg_armed_q <= 1'b1;
    end else begin
      if (!tx_cfg_req) cfg_armed_q <= 1'b1;
      case (state_q)
        IDLE: begin
          // Config requests outrank new packets; tx_buf_av only matters here
          if (tx_cfg_req && (CFG_HOLD || cfg_armed_q)) begin
            state_q     <= CFG;
            gnt_q       <= 1'b1;
            cfg_armed_q <= 1'b0;
          end else if (buf_ok_d && (r0_tvalid || r1_tvalid)) begin
            state_q    <= pick_d ? GNT1 : GNT0;
            busy_q     <= 1'b1;
            grant_id_q <= pick_d;
          end
        end
        GNT0: begin
          if (r0_tvalid && s_axis_tx_tready && r0_tlast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= 1'b1;
          end
        end
        GNT1: begin
          if (r1_tvalid && s_axis_tx_tready && r1_tlast) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            rr_q    <= 1'b0;
          end
        end
        CFG: begin
          // Hold mode releases once req drops; pulse mode always leaves after one cycle
          if (!CFG_HOLD || !tx_cfg_req) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating increment of the dropped-TLP counter
  always_comb begin
    drop_count_d = drop_count_q;
    if (tx_err_drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
  end

  // Dropped-TLP counter register, counts in every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_count_q <= 16'd0;
    else     drop_count_q <= drop_count_d;
  end

  assign tx_cfg_gnt = gnt_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign drop_count = drop_count_q;

endmodule
